dump_engine: RTL and testbench

Synthesizable end-of-run state dump unit for the pipelined core. When the core raises its halt flag, the block walks the register file and then a window of data memory, streaming each word out over a valid/ready port. It replaces simulation-only halt dumps so that hardware runs and FPGA runs can export architectural state. It sits beside `top`, borrows the register-file read port and the data-memory address port while dumping, and feeds a host-side sink such as a UART or FIFO.

---
 rtl/dump_engine_if.sv | 17 +
 rtl/dump_engine.sv | 217 +++++++++++++++++++++
 tb/tb_dump_engine.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_engine_if.sv
// dump_engine_if: valid/ready stream carrying the dumped state words.
//   data  : stream word
//   valid : word present (source)
//   ready : sink accepts (sink)
//   last  : final word of the stream (source)
// master = dump engine side, slave = sink side.
interface dump_engine_if #(
    parameter int unsigned W_DATA = 32
);
    logic [W_DATA-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/dump_engine.sv
// dump_engine: on core halt, streams the register file and then a window of
// data memory out over a valid/ready port so hardware runs can export
// architectural state.
// Optional feature macro: DUMP_CHECKSUM_EN appends the XOR of all streamed
// words as one extra final word.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   hlt_i        : core halt flag, starts the dump (pulse is enough)
//   reg_addr_o   : register-file read index
//   reg_data_i   : register-file read data (combinational from reg_addr_o)
//   mem_addr_o   : data-memory address
//   mem_data_i   : data-memory Q (one-cycle synchronous read)
//   mem_sel_o    : engine owns the memory address port while high
//   dump         : stream interface (master modport)
//   busy_o       : dump in progress
//   done_o       : dump complete, sticky until reset
module dump_engine #(
    parameter int unsigned W_DATA   = 32,
    parameter int unsigned N_REG    = 16,
    parameter int unsigned REG_ADDR = 4,
    parameter int unsigned N_MEM    = 16,
    parameter int unsigned MEM_ADDR = 8,
    parameter int unsigned MEM_BASE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hlt_i,
    output logic [REG_ADDR-1:0] reg_addr_o,
    input  logic [W_DATA-1:0]   reg_data_i,
    output logic [MEM_ADDR-1:0] mem_addr_o,
    input  logic [W_DATA-1:0]   mem_data_i,
    output logic                mem_sel_o,
    dump_engine_if.master       dump,
    output logic                busy_o,
    output logic                done_o
);
    localparam int unsigned N_MAX = (N_REG > N_MEM) ? N_REG : N_MEM;
    localparam int unsigned IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REG_RD  = 3'd1,
        S_REG_OUT = 3'd2,
        S_MEM_RD  = 3'd3,
        S_MEM_OUT = 3'd4,
`ifdef DUMP_CHECKSUM_EN
        S_SUM_OUT = 3'd5,
`endif
        S_DONE    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ph_q, ph_d;          // MEM_RD sub-cycle: 0 = address, 1 = capture
    logic [W_DATA-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                sel_q, sel_d;
    logic                done_q, done_d;
    logic [MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
`ifdef DUMP_CHECKSUM_EN
    logic [W_DATA-1:0]   chk_q, chk_d;
`endif
    logic                xfer;

    assign xfer       = valid_q & dump.ready;
    assign reg_addr_o = REG_ADDR'(idx_q);
    assign mem_addr_o = mem_addr_q;
    assign mem_sel_o  = sel_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign dump.data  = data_q;
    assign dump.valid = valid_q;
    assign dump.last  = last_q;

    // Next-state and output-register logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ph_d       = ph_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        sel_d      = sel_q;
        done_d     = done_q;
        mem_addr_d = mem_addr_q;
`ifdef DUMP_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (hlt_i) begin
                    state_d = S_REG_RD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_REG_RD: begin
                data_d  = reg_data_i;
                valid_d = 1'b1;
                state_d = S_REG_OUT;
            end
            S_REG_OUT: begin
                if (xfer) begin
                    valid_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    chk_d   = chk_q ^ data_q;
`endif
                    if (idx_q == IDX_W'(N_REG - 1)) begin
                        idx_d      = '0;
                        ph_d       = 1'b0;
                        sel_d      = 1'b1;
                        mem_addr_d = MEM_ADDR'(MEM_BASE);
                        state_d    = S_MEM_RD;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_REG_RD;
                    end
                end
            end
            S_MEM_RD: begin
                // Address is presented for one cycle; Q is captured the next.
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d    = 1'b0;
                    data_d  = mem_data_i;
                    valid_d = 1'b1;
`ifndef DUMP_CHECKSUM_EN
                    last_d  = (idx_q == IDX_W'(N_MEM - 1));
`endif
                    state_d = S_MEM_OUT;
                end
            end
            S_MEM_OUT: begin
                if (xfer) begin
`ifdef DUMP_CHECKSUM_EN
                    chk_d = chk_q ^ data_q;
`endif
                    if (idx_q == IDX_W'(N_MEM - 1)) begin
`ifdef DUMP_CHECKSUM_EN
                        // Checksum word follows directly; valid stays high.
                        data_d  = chk_q ^ data_q;
                        last_d  = 1'b1;
                        sel_d   = 1'b0;
                        state_d = S_SUM_OUT;
`else
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        sel_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
`endif
                    end else begin
                        valid_d    = 1'b0;
                        idx_d      = idx_q + IDX_W'(1);
                        mem_addr_d = mem_addr_q + MEM_ADDR'(1);
                        state_d    = S_MEM_RD;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_SUM_OUT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ph_q       <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ph_q       <= ph_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
`ifdef DUMP_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_dump_engine.sv
// Self-checking bench for dump_engine: register file and memory models,
// expected stream built from the array contents, randomized sink ready.
module tb_dump_engine;
    localparam int NR = 16;
    localparam int NM = 16;
`ifdef DUMP_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, hlt, hlt2;
    logic [3:0]  reg_addr, reg_addr2;
    logic [31:0] reg_data, reg_data2;
    logic [7:0]  mem_addr, mem_addr2;
    logic [31:0] mem_data, mem_data2;
    logic        mem_sel, mem_sel2, busy, busy2, done, done2;
    logic [31:0] rf [16];
    logic [31:0] dm [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_word_seen;
    int          n_pass = 0;
    int          n_chk  = 0;

    always #5 clk = ~clk;

    dump_engine_if #(.W_DATA(32)) dif ();
    dump_engine_if #(.W_DATA(32)) dif2 ();

    assign reg_data  = rf[reg_addr];
    assign reg_data2 = rf[reg_addr2];

    always @(posedge clk) begin
        mem_data  <= dm[mem_addr];
        mem_data2 <= dm[mem_addr2];
    end

    dump_engine u_dut (
        .clk(clk), .reset(reset), .hlt_i(hlt),
        .reg_addr_o(reg_addr), .reg_data_i(reg_data),
        .mem_addr_o(mem_addr), .mem_data_i(mem_data), .mem_sel_o(mem_sel),
        .dump(dif), .busy_o(busy), .done_o(done)
    );

    dump_engine #(.N_REG(2), .N_MEM(4), .MEM_ADDR(8), .MEM_BASE(254)) u_wrap (
        .clk(clk), .reset(reset), .hlt_i(hlt2),
        .reg_addr_o(reg_addr2), .reg_data_i(reg_data2),
        .mem_addr_o(mem_addr2), .mem_data_i(mem_data2), .mem_sel_o(mem_sel2),
        .dump(dif2), .busy_o(busy2), .done_o(done2)
    );

    // Expected stream: registers 0..nreg-1, then memory base..base+nmem-1 (mod 256)
    function automatic void build_exp(input int nreg, input int nmem, input int base);
        logic [7:0] a;
        exp_q.delete();
        for (int i = 0; i < nreg; i++) exp_q.push_back(rf[i]);
        for (int j = 0; j < nmem; j++) begin
            a = 8'(base + j);
            exp_q.push_back(dm[a]);
        end
`ifdef DUMP_CHECKSUM_EN
        begin
            logic [31:0] s;
            s = '0;
            foreach (exp_q[k]) s ^= exp_q[k];
            exp_q.push_back(s);
        end
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
        for (int j = 0; j < 256; j++) dm[j] = 32'hA000 + 32'(j);
    endtask

    // mode 0: ready always 1, 1: random ready, 2: 5-cycle stall on word 3
    task automatic run_stream(input int mode);
        int n, first_v, done_c, stall_cnt, sel_bad;
        logic pv, pr, pl;
        logic [31:0] pd;
        build_exp(NR, NM, 0);
        n = 0; first_v = -1; done_c = -1; stall_cnt = 0; sel_bad = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        @(negedge clk);
        hlt = 1'b1;
        dif.ready = 1'b1;
        @(negedge clk);
        hlt = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            if (dif.valid && first_v < 0) first_v = c;
            case (mode)
                0: dif.ready = 1'b1;
                1: dif.ready = 1'($urandom_range(0, 1));
                default: begin
                    dif.ready = 1'b1;
                    if (dif.valid && n == 3 && stall_cnt < 5) begin
                        dif.ready = 1'b0;
                        stall_cnt++;
                    end
                end
            endcase
            if (n < NR && mem_sel) sel_bad++;
            if (pv && !pr) begin
                n_chk++;
                if (dif.valid !== 1'b1 || dif.data !== pd || dif.last !== pl)
                    $display("FAIL hold: got v=%b d=%h l=%b exp v=1 d=%h l=%b", dif.valid, dif.data, dif.last, pd, pl);
                else n_pass++;
            end
            if (dif.valid && dif.ready) begin
                n_chk++;
                if (n >= exp_q.size())
                    $display("FAIL extra word %0d: got %h exp none", n, dif.data);
                else if (dif.data !== exp_q[n] || dif.last !== (n == exp_q.size() - 1))
                    $display("FAIL word %0d: got %h last=%b exp %h last=%b", n, dif.data, dif.last, exp_q[n], (n == exp_q.size() - 1));
                else n_pass++;
                last_word_seen = dif.data;
                n++;
            end
            pv = dif.valid; pr = dif.ready; pd = dif.data; pl = dif.last;
            @(negedge clk);
        end
        n_chk++;
        if (done_c < 0) $display("FAIL timeout: got no done exp done");
        else n_pass++;
        n_chk++;
        if (n != exp_q.size()) $display("FAIL count: got %0d exp %0d", n, exp_q.size());
        else n_pass++;
        n_chk++;
        if (first_v != 1) $display("FAIL first_valid: got %0d exp 1", first_v);
        else n_pass++;
        n_chk++;
        if (sel_bad != 0) $display("FAIL sel_in_reg_phase: got %0d exp 0", sel_bad);
        else n_pass++;
        n_chk++;
        if (dif.valid !== 1'b0 || busy !== 1'b0 || mem_sel !== 1'b0)
            $display("FAIL done_outputs: got v=%b b=%b s=%b exp 0 0 0", dif.valid, busy, mem_sel);
        else n_pass++;
        if (mode == 0) begin
            n_chk++;
            if (done_c != 2 * NR + 3 * NM + CHK_EXTRA)
                $display("FAIL done_cycle: got %0d exp %0d", done_c, 2 * NR + 3 * NM + CHK_EXTRA);
            else n_pass++;
        end
        if (mode == 2) begin
            n_chk++;
            if (stall_cnt != 5) $display("FAIL stall_cnt: got %0d exp 5", stall_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (dif.valid !== 1'b0 || dif.last !== 1'b0 || dif.data !== 32'h0)
            $display("FAIL reset_stream: got v=%b l=%b d=%h exp 0 0 0", dif.valid, dif.last, dif.data);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_sel !== 1'b0)
            $display("FAIL reset_status: got b=%b d=%b s=%b exp 0 0 0", busy, done, mem_sel);
        else n_pass++;
        n_chk++;
        if (reg_addr !== 4'h0 || mem_addr !== 8'h00)
            $display("FAIL reset_addr: got r=%h m=%h exp 0 0", reg_addr, mem_addr);
        else n_pass++;
        n_chk++;
        if (dif2.valid !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0)
            $display("FAIL reset_wrap: got v=%b b=%b d=%b exp 0 0 0", dif2.valid, busy2, done2);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        fill_pattern();
        do_reset();
        run_stream(0);
    endtask

    task automatic test_backpressure();
        fill_pattern();
        do_reset();
        run_stream(2);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 16; i++) rf[i] = $urandom;
            for (int j = 0; j < 256; j++) dm[j] = $urandom;
            do_reset();
            run_stream(1);
        end
    endtask

    task automatic test_checksum();
        for (int i = 0; i < 16; i++) rf[i] = '0;
        for (int j = 0; j < 256; j++) dm[j] = '0;
        rf[1] = 32'h0F0F0F0F;
        dm[2] = 32'hFFFF0000;
        do_reset();
        run_stream(0);
        n_chk++;
`ifdef DUMP_CHECKSUM_EN
        if (last_word_seen !== 32'hF0F00F0F) $display("FAIL checksum_word: got %h exp f0f00f0f", last_word_seen);
        else n_pass++;
`else
        if (last_word_seen !== 32'h0) $display("FAIL final_word: got %h exp 00000000", last_word_seen);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int got;
        fill_pattern();
        do_reset();
        got = 0;
        @(negedge clk);
        hlt = 1'b1;
        dif.ready = 1'b1;
        @(negedge clk);
        hlt = 1'b0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            if (dif.valid && dif.ready) got++;
            @(negedge clk);
        end
        n_chk++;
        if (got != 5) $display("FAIL mid_transfers: got %0d exp 5", got);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (dif.valid !== 1'b0 || busy !== 1'b0 || mem_sel !== 1'b0 || done !== 1'b0 || dif.last !== 1'b0)
            $display("FAIL mid_reset: got v=%b b=%b s=%b d=%b l=%b exp all 0", dif.valid, busy, mem_sel, done, dif.last);
        else n_pass++;
        reset = 1'b0;
        run_stream(0);
    endtask

    task automatic test_hold_hlt();
        int v_cnt, nd_cnt, s_cnt;
        v_cnt = 0; nd_cnt = 0; s_cnt = 0;
        @(negedge clk);
        hlt = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dif.valid) v_cnt++;
            if (!done) nd_cnt++;
            if (mem_sel || busy) s_cnt++;
        end
        hlt = 1'b0;
        n_chk++;
        if (v_cnt != 0) $display("FAIL hold_hlt_valid: got %0d exp 0", v_cnt);
        else n_pass++;
        n_chk++;
        if (nd_cnt != 0) $display("FAIL hold_hlt_done: got %0d exp 0", nd_cnt);
        else n_pass++;
        n_chk++;
        if (s_cnt != 0) $display("FAIL hold_hlt_sel_busy: got %0d exp 0", s_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] addr_q [$];
        logic [7:0] ea;
        int n;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        for (int j = 0; j < 256; j++) dm[j] = $urandom;
        build_exp(2, 4, 254);
        do_reset();
        n = 0;
        @(negedge clk);
        hlt2 = 1'b1;
        @(negedge clk);
        hlt2 = 1'b0;
        for (int c = 0; c < 500 && !done2; c++) begin
            dif2.ready = 1'($urandom_range(0, 1));
            if (mem_sel2 && (addr_q.size() == 0 || addr_q[$] != mem_addr2)) addr_q.push_back(mem_addr2);
            if (dif2.valid && dif2.ready) begin
                n_chk++;
                if (n >= exp_q.size())
                    $display("FAIL wrap_extra %0d: got %h exp none", n, dif2.data);
                else if (dif2.data !== exp_q[n] || dif2.last !== (n == exp_q.size() - 1))
                    $display("FAIL wrap_word %0d: got %h last=%b exp %h", n, dif2.data, dif2.last, exp_q[n]);
                else n_pass++;
                n++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (!done2 || n != exp_q.size()) $display("FAIL wrap_count: got %0d done=%b exp %0d done=1", n, done2, exp_q.size());
        else n_pass++;
        n_chk++;
        if (addr_q.size() != 4) $display("FAIL wrap_addr_count: got %0d exp 4", addr_q.size());
        else n_pass++;
        for (int j = 0; j < 4 && j < addr_q.size(); j++) begin
            ea = 8'(254 + j);
            n_chk++;
            if (addr_q[j] !== ea) $display("FAIL wrap_addr %0d: got %h exp %h", j, addr_q[j], ea);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        hlt = 1'b0;
        hlt2 = 1'b0;
        dif.ready = 1'b0;
        dif2.ready = 1'b0;
        last_word_seen = '0;
        test_reset();
        test_basic();
        test_hold_hlt();
        test_backpressure();
        test_random();
        test_checksum();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
